lut_layer_stream_ctrl: RTL and testbench
========================================

// Module: lut_layer_stream_ctrl
// PURPOSE
//  Valid/ready sequencer around a free-running LUT-neuron layer (case-ROM neurons, 2-bit activations).
//  Registers each accepted input vector onto lut_in, tracks it through PIPE_STAGES external register stages,
//  captures lut_out into an output FIFO and exerts credit-based backpressure. Provides a drain handshake
//  for the autoencoder top. One instance per layer boundary that needs stalling.
// PARAMETERS
//  IN_W        8   width of packed input vector (fan-in x input bits)
//  OUT_W       2   width of packed layer output
//  PIPE_STAGES 0   register stages inside external layer between lut_in and lut_out (0 = purely combinational)
//  FIFO_DEPTH  4   output FIFO entries, power of two, >= 2
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst         in   1      synchronous, active-high reset
//  s_valid     in   1      input vector valid
//  s_ready     out  1      controller can accept
//  s_data      in   IN_W   input vector
//  lut_in      out  IN_W   registered vector to layer
//  lut_out     in   OUT_W  layer result, PIPE_STAGES cycles behind lut_in
//  m_valid     out  1      FIFO head valid
//  m_ready     in   1      downstream accepts
//  m_data      out  OUT_W  FIFO head data
//  drain_req   in   1      level/pulse: stop accepting, empty pipeline and FIFO
//  draining    out  1      high while in DRAIN
//  drain_done  out  1      one-cycle pulse when drain completes
//  in_count    out  16     accepted-vector counter, wraps
//  out_count   out  16     delivered-vector counter, wraps
// BEHAVIOUR
//  - Reset: s_ready=0 in reset cycle then per credit rule; lut_in=0; valid pipe cleared; FIFO empty; m_valid=0;
//    draining=0; drain_done=0; counters=0; state=RUN. rst mid-operation discards all in-flight/FIFO data.
//  - Accept: s_valid&&s_ready at edge k -> lut_in<=s_data; vpipe[0]<=1. lut_in holds when no accept.
//  - vpipe: PIPE_STAGES+1 bit shift register, shifts every cycle (layer is free-running, no enable).
//  - Capture: vpipe[PIPE_STAGES]=1 -> lut_out written to FIFO at that edge (edge k+PIPE_STAGES+1);
//    m_valid visible after that edge. Latency accept->m_valid = PIPE_STAGES+1 cycles; no bypass.
//  - Credit: inflight=popcount(vpipe); s_ready = (state==RUN) && (fifo_count+inflight < FIFO_DEPTH).
//    Same-cycle pop not credited (no m_ready->s_ready path). Overflow of FIFO is unreachable; assert it.
//  - Output: pop on m_valid&&m_ready; m_data stable while m_valid&&!m_ready. Push+pop same edge legal
//    incl. full and empty-with-push (count unchanged / becomes 1 respectively).
//  - Counters: in_count++ on accept, out_count++ on pop, modulo 2^16.
//  - FSM: RUN -> DRAIN when drain_req=1 (s_ready forced 0 from next cycle; same-cycle accept still counted).
//    DRAIN -> DONE when inflight==0 && fifo empty; DONE lasts 1 cycle (drain_done=1) -> RUN,
//    unless drain_req still high: then stay DRAIN with drain_done already pulsed once (no repeat pulses).
//    drain_req in DRAIN/DONE ignored otherwise. draining=1 in DRAIN and DONE.
// STRUCTURE
//  - Package lut_ctrl_pkg: state enum {ST_RUN, ST_DRAIN, ST_DONE}; clog2-based width helpers;
//    COUNT_W=16 constant.
//  - Sub-module lut_ctrl_fifo: synchronous FIFO, depth FIFO_DEPTH, width OUT_W, count output, registered read data.
//  - Top holds input reg, vpipe, credit logic, FSM, counters.
// TESTING
//  - Reset: rst high 2 cycles with s_valid=1 -> no accept, m_valid=0, counters 0, s_ready=1 first cycle after.
//  - Streaming PIPE_STAGES=0, model lut_out=f(lut_in), m_ready=1: 100 back-to-back vectors -> 100 outputs
//    in order, first m_valid 1 cycle after first accept, in_count=out_count=100.
//  - Backpressure FIFO_DEPTH=4, PIPE_STAGES=2, m_ready=0: exactly 4 accepts then s_ready=0; raise m_ready
//    -> 4 outputs unchanged order, s_ready returns 1 cycle after first pop.
//  - Drain: 3 in flight, assert drain_req 1 cycle -> s_ready=0 next cycle, 3 outputs delivered,
//    drain_done single pulse after last pop, back to RUN with s_ready=1.
//  - Reset mid-stream with FIFO holding 3 entries -> FIFO empty, m_valid=0, no stale output after release.
//  - Counter wrap: preload-equivalent 65537 accepts -> in_count=1.

Source files
------------

// File: rtl/lut_ctrl_pkg.sv
// Shared definitions for the LUT-layer stream controller.
//   state_e  : sequencer states (run, draining, drain complete)
//   COUNT_W  : width of the accepted/delivered vector counters
//   ptr_w()  : address width for a power-of-two storage depth
//   cnt_w()  : width able to hold the values 0..n inclusive
package lut_ctrl_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lut_ctrl_fifo.sv
// Synchronous output FIFO with a registered head.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write wr_data (caller guarantees no overflow)
//   wr_data   : data to write
//   pop       : remove head (ignored when empty)
//   rd_data   : registered head data, stable until the next pop
//   valid     : FIFO holds at least one entry
//   count     : number of entries held (0..DEPTH)
module lut_ctrl_fifo
  import lut_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    head_idx;
  logic [WIDTH-1:0] head_nxt;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;

  // The head register must show the entry that will be at the front after
  // this edge. When that entry is the one being written right now it is not
  // in mem yet, so forward wr_data (empty+push, or one entry with push+pop).
  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    head_idx = do_pop ? rd_ptr + PW'(1) : rd_ptr;
    head_nxt = (push && (head_idx == wr_ptr)) ? wr_data : mem[head_idx];
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push || do_pop) rd_data <= head_nxt;
    end
  end

  // NOTE: the storage array has no reset; count/pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Credit accounting upstream makes a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !do_pop && (count == CW'(DEPTH))));
    end
  end

endmodule

// File: rtl/lut_layer_stream_ctrl.sv
// Valid/ready sequencer around a free-running LUT-neuron layer.
//   clk, rst          : clock, synchronous active-high reset
//   s_valid/s_ready   : input vector handshake, s_data is the vector
//   lut_in            : registered vector driving the external layer
//   lut_out           : layer result, PIPE_STAGES cycles behind lut_in
//   m_valid/m_ready   : output handshake, m_data is the FIFO head
//   drain_req         : stop accepting and empty pipeline + FIFO
//   draining          : high in DRAIN and DONE
//   drain_done        : one-cycle pulse when a drain completes
//   in_count          : accepted vectors, wraps
//   out_count         : delivered vectors, wraps
module lut_layer_stream_ctrl
  import lut_ctrl_pkg::*;
#(
  parameter int IN_W        = 8,
  parameter int OUT_W       = 2,
  parameter int PIPE_STAGES = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IN_W-1:0]    s_data,
  output logic [IN_W-1:0]    lut_in,
  input  logic [OUT_W-1:0]   lut_out,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  input  logic               drain_req,
  output logic               draining,
  output logic               drain_done,
  output logic [COUNT_W-1:0] in_count,
  output logic [COUNT_W-1:0] out_count
);

  localparam int FCW = cnt_w(FIFO_DEPTH);
  localparam int CRW = cnt_w(FIFO_DEPTH + PIPE_STAGES + 1);

  state_e             state;
  logic               drain_pulsed;
  logic [PIPE_STAGES:0] vpipe;
  logic [FCW-1:0]     fifo_count;
  logic [CRW-1:0]     inflight;
  logic [CRW-1:0]     credit_used;
  logic               accept;
  logic               pop;
  logic               all_empty;

  // Vectors in the layer pipeline still owe a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= PIPE_STAGES; i++) inflight = inflight + CRW'(vpipe[i]);
  end

  assign credit_used = CRW'(fifo_count) + inflight;
  assign all_empty   = (inflight == '0) && (fifo_count == '0);

  // rst gates s_ready directly so nothing looks acceptable during the reset
  // cycle. A pop in this cycle is deliberately not credited back yet.
  assign s_ready = !rst && (state == ST_RUN) && (credit_used < CRW'(FIFO_DEPTH));
  assign accept  = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Input register, valid tracker and counters. vpipe shifts every cycle
  // because the layer itself has no enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_in    <= '0;
      vpipe     <= '0;
      in_count  <= '0;
      out_count <= '0;
    end else begin
      if (accept) begin
        lut_in   <= s_data;
        in_count <= in_count + COUNT_W'(1);
      end
      vpipe[0] <= accept;
      for (int i = 1; i <= PIPE_STAGES; i++) vpipe[i] <= vpipe[i-1];
      if (pop) out_count <= out_count + COUNT_W'(1);
    end
  end

  // Drain sequencer. drain_pulsed remembers that DONE already fired for a
  // drain_req that is still held, so DRAIN then waits for its release
  // instead of pulsing again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      drain_pulsed <= 1'b0;
      draining     <= 1'b0;
      drain_done   <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (drain_req) begin
            state        <= ST_DRAIN;
            drain_pulsed <= 1'b0;
            draining     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (all_empty) begin
            if (!drain_pulsed) begin
              state      <= ST_DONE;
              drain_done <= 1'b1;
            end else if (!drain_req) begin
              state    <= ST_RUN;
              draining <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (drain_req) begin
            state        <= ST_DRAIN;
            drain_pulsed <= 1'b1;
          end else begin
            state    <= ST_RUN;
            draining <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          draining <= 1'b0;
        end
      endcase
    end
  end

  lut_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (vpipe[PIPE_STAGES]),
    .wr_data (lut_out),
    .pop     (pop),
    .rd_data (m_data),
    .valid   (m_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_lut_layer_stream_ctrl.sv
// Directed bench: u_p0 has a combinational layer (PIPE_STAGES=0), u_p2 has a
// two-register layer (PIPE_STAGES=2); both use a 4-entry output FIFO.
module tb_lut_layer_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u_p0 signals
  logic        s_valid0, s_ready0, m_valid0, m_ready0, drain_req0, draining0, drain_done0;
  logic [7:0]  s_data0, lut_in0;
  logic [1:0]  lut_out0, m_data0;
  logic [15:0] in_count0, out_count0;
  // u_p2 signals
  logic        s_valid2, s_ready2, m_valid2, m_ready2, drain_req2, draining2, drain_done2;
  logic [7:0]  s_data2, lut_in2;
  logic [1:0]  lut_out2, m_data2, st1, st2;
  logic [15:0] in_count2, out_count2;

  int n_checks = 0;
  int n_fail   = 0;

  // Layer function used by both layer models.
  function automatic logic [1:0] f(input logic [7:0] x);
    return x[1:0] ^ x[7:6];
  endfunction

  function automatic logic [7:0] vec(input int i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Combinational layer for u_p0, two-register layer for u_p2.
  assign lut_out0 = f(lut_in0);
  always @(posedge clk) begin
    st1 <= f(lut_in2);
    st2 <= st1;
  end
  assign lut_out2 = st2;

  lut_layer_stream_ctrl #(.IN_W(8), .OUT_W(2), .PIPE_STAGES(0), .FIFO_DEPTH(4)) u_p0 (
    .clk(clk), .rst(rst), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .lut_in(lut_in0), .lut_out(lut_out0), .m_valid(m_valid0), .m_ready(m_ready0),
    .m_data(m_data0), .drain_req(drain_req0), .draining(draining0),
    .drain_done(drain_done0), .in_count(in_count0), .out_count(out_count0)
  );

  lut_layer_stream_ctrl #(.IN_W(8), .OUT_W(2), .PIPE_STAGES(2), .FIFO_DEPTH(4)) u_p2 (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .lut_in(lut_in2), .lut_out(lut_out2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_data(m_data2), .drain_req(drain_req2), .draining(draining2),
    .drain_done(drain_done2), .in_count(in_count2), .out_count(out_count2)
  );

  initial begin
    int nin, nout, cyc, first_acc, first_mv, acc_edge;
    int npop, last_pop, done_cnt, done_cyc, acc, stale;

    // ---------------- reset with s_valid held high ----------------
    rst = 1'b1;
    s_valid0 = 1'b1; s_data0 = 8'hA5; m_ready0 = 1'b0; drain_req0 = 1'b0;
    s_valid2 = 1'b1; s_data2 = 8'h3C; m_ready2 = 1'b0; drain_req2 = 1'b0;
    @(negedge clk);
    check("rst_cycle0_s_ready", s_ready0, 0);
    @(negedge clk);
    check("rst_cycle1_s_ready", s_ready0, 0);
    check("rst_cycle1_m_valid", m_valid0, 0);
    @(negedge clk);
    rst = 1'b0; s_valid0 = 1'b0; s_valid2 = 1'b0;
    #1;
    check("post_rst_s_ready0", s_ready0, 1);
    check("post_rst_s_ready2", s_ready2, 1);
    check("post_rst_m_valid0", m_valid0, 0);
    check("post_rst_m_valid2", m_valid2, 0);
    check("post_rst_in_count0", in_count0, 0);
    check("post_rst_out_count0", out_count0, 0);
    check("post_rst_lut_in0", lut_in0, 0);
    check("post_rst_draining0", draining0, 0);
    check("post_rst_drain_done0", drain_done0, 0);
    check("post_rst_draining2", draining2, 0);
    check("post_rst_drain_done2", drain_done2, 0);

    // ---------------- streaming, 100 vectors, PIPE_STAGES=0 ----------------
    nin = 0; nout = 0; cyc = 0; first_acc = -1; first_mv = -1;
    m_ready0 = 1'b1;
    while ((nin < 100 || nout < 100) && cyc < 400) begin
      if (m_valid0) begin
        if (first_mv < 0) first_mv = cyc;
        check("stream_data", m_data0, f(vec(nout)));
        nout++;
      end
      s_valid0 = (nin < 100);
      s_data0  = vec(nin);
      #1;
      if (s_valid0 && s_ready0) begin
        if (first_acc < 0) first_acc = cyc;
        nin++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid0 = 1'b0;
    // An accept sampled in window first_acc happens on edge first_acc+1;
    // m_valid must be visible one edge later.
    acc_edge = first_acc + 1;
    check("stream_latency", first_mv - acc_edge, 1);
    check("stream_nout", nout, 100);
    check("stream_in_count", in_count0, 100);
    check("stream_out_count", out_count0, 100);

    // ---------------- drain with 3 in flight ----------------
    m_ready0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid0 = 1'b1; s_data0 = vec(300 + k);
      #1;
      check("drain_fill_ready", s_ready0, 1);
      @(negedge clk);
    end
    s_valid0 = 1'b0; drain_req0 = 1'b1;
    @(negedge clk);
    drain_req0 = 1'b0;
    #1;
    check("drain_s_ready_low", s_ready0, 0);
    check("drain_draining", draining0, 1);
    check("drain_in_count", in_count0, 103);
    m_ready0 = 1'b1;
    npop = 0; last_pop = -1; done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < 10; c++) begin
      if (drain_done0) begin
        done_cnt++; done_cyc = c;
        check("drain_done_draining", draining0, 1);
      end
      if (m_valid0) begin
        check("drain_data", m_data0, f(vec(300 + npop)));
        npop++; last_pop = c;
      end
      @(negedge clk);
      #1;
    end
    check("drain_npop", npop, 3);
    check("drain_done_pulses", done_cnt, 1);
    check("drain_done_timing", done_cyc - last_pop, 2);
    check("drain_back_ready", s_ready0, 1);
    check("drain_back_draining", draining0, 0);
    check("drain_out_count", out_count0, 103);

    // ---------------- drain_req held high: only one pulse ----------------
    drain_req0 = 1'b1; done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (drain_done0) done_cnt++;
    end
    check("held_drain_pulses", done_cnt, 1);
    check("held_drain_draining", draining0, 1);
    check("held_drain_s_ready", s_ready0, 0);
    drain_req0 = 1'b0;
    @(negedge clk);
    #1;
    check("held_release_draining", draining0, 0);
    check("held_release_s_ready", s_ready0, 1);

    // ---------------- backpressure, PIPE_STAGES=2 ----------------
    m_ready2 = 1'b0; acc = 0;
    for (int c = 0; c < 12; c++) begin
      s_valid2 = 1'b1; s_data2 = vec(200 + acc);
      #1;
      if (s_ready2) acc++;
      @(negedge clk);
    end
    s_valid2 = 1'b0;
    #1;
    check("bp_accepts", acc, 4);
    check("bp_s_ready_low", s_ready2, 0);
    check("bp_m_valid", m_valid2, 1);
    check("bp_head_stable", m_data2, f(vec(200)));
    check("bp_in_count", in_count2, 4);
    check("bp_out_count", out_count2, 0);
    m_ready2 = 1'b1; npop = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) check("bp_ready_before_pop", s_ready2, 0);
      if (c == 1) check("bp_ready_after_pop", s_ready2, 1);
      if (m_valid2) begin
        check("bp_data", m_data2, f(vec(200 + npop)));
        npop++;
      end
      @(negedge clk);
      #1;
    end
    check("bp_npop", npop, 4);
    check("bp_out_count_after", out_count2, 4);

    // ---------------- reset mid-stream with 3 entries held ----------------
    m_ready2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid2 = 1'b1; s_data2 = vec(400 + k);
      #1;
      check("mrst_fill_ready", s_ready2, 1);
      @(negedge clk);
    end
    s_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("mrst_pre_m_valid", m_valid2, 1);
    check("mrst_pre_in_count", in_count2, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_m_valid", m_valid2, 0);
    check("mrst_s_ready", s_ready2, 1);
    check("mrst_in_count", in_count2, 0);
    check("mrst_out_count", out_count2, 0);
    m_ready2 = 1'b1; stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (m_valid2) stale++;
    end
    check("mrst_no_stale", stale, 0);

    // ---------------- counter wrap on u_p0 (fresh from reset) ----------------
    @(negedge clk);
    m_ready0 = 1'b1; acc = 0; cyc = 0;
    while (acc < 65537 && cyc < 70000) begin
      s_valid0 = 1'b1; s_data0 = 8'(acc);
      #1;
      if (s_ready0) acc++;
      @(negedge clk);
      cyc++;
    end
    s_valid0 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("wrap_accepts", acc, 65537);
    check("wrap_in_count", in_count0, 1);
    check("wrap_out_count", out_count0, 1);
    check("wrap_m_valid", m_valid0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
